// File: rtl/intctl_multi_if.sv
// Unibus side of the interrupt requester: arbitration lines and vector data bus.
interface intctl_multi_if;
    logic        bbsy_in_h;
    logic        bg_in_l;
    logic        init_in_h;
    logic        syn_msyn_in_h;
    logic        syn_ssyn_in_h;
    logic        bbsy_out_h;
    logic        br_out_h;
    logic        intr_out_h;
    logic        sack_out_h;
    logic [15:0] d_out_h;

    modport master (
        input  bbsy_in_h, bg_in_l, init_in_h, syn_msyn_in_h, syn_ssyn_in_h,
        output bbsy_out_h, br_out_h, intr_out_h, sack_out_h, d_out_h
    );

    modport slave (
        output bbsy_in_h, bg_in_l, init_in_h, syn_msyn_in_h, syn_ssyn_in_h,
        input  bbsy_out_h, br_out_h, intr_out_h, sack_out_h, d_out_h
    );
endinterface

// File: rtl/intctl_multi.sv
// Single-level Unibus interrupt requester shared by NCHAN channels.
// Define INTCTL_MULTI_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module intctl_multi #(
    parameter int NCHAN    = 4,
    parameter int DEGLITCH = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [8*NCHAN-1:0] intvecs,
    intctl_multi_if.master     bus,
    output logic [NCHAN-1:0]   intack_out_h,
    output logic               tmo_out_h
);
    localparam int IDXW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int DGW  = $clog2(DEGLITCH) + 1;
    localparam int TMW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SACK, S_INTR} state_e;

    state_e           state_q, state_d;
    logic [DGW-1:0]   dg_cnt_q, dg_cnt_d;
    logic [TMW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [IDXW-1:0]  win_q, win_d;
    logic             br_q, br_d, sack_q, sack_d, bbsy_q, bbsy_d, intr_q, intr_d;
    logic [15:0]      d_q, d_d;
    logic [NCHAN-1:0] ack_q, ack_d;
    logic             tmo_q, tmo_d;

    logic [NCHAN-1:0] req;
    logic             any_req, bus_free, pick_ok;
    logic [IDXW-1:0]  pick;
    logic [7:0]       pick_vec;

    // Vector bit0 set means the channel has nothing pending.
    always_comb begin
        req = '0;
        for (int k = 0; k < NCHAN; k++) req[k] = ~intvecs[8*k];
    end

    assign any_req  = |req;
    assign bus_free = ~bus.bbsy_in_h & bus.bg_in_l & ~bus.syn_msyn_in_h & ~bus.syn_ssyn_in_h;

`ifdef INTCTL_MULTI_RR_EN
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] scan;

    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        scan    = ptr_q;
        for (int k = 0; k < NCHAN; k++) begin
            if (!pick_ok && req[scan]) begin
                pick_ok = 1'b1;
                pick    = scan;
            end
            scan = (scan == IDXW'(NCHAN - 1)) ? '0 : scan + 1'b1;
        end
    end
`else
    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        for (int k = NCHAN - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick_ok = 1'b1;
                pick    = IDXW'(k);
            end
        end
    end
`endif

    always_comb begin
        pick_vec = 8'h00;
        for (int k = 0; k < NCHAN; k++)
            if (pick == IDXW'(k)) pick_vec = intvecs[8*k +: 8];
    end

    always_comb begin
        state_d   = state_q;
        dg_cnt_d  = dg_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        win_d     = win_q;
        br_d      = br_q;
        sack_d    = sack_q;
        bbsy_d    = bbsy_q;
        intr_d    = intr_q;
        d_d       = d_q;
        ack_d     = '0;
        tmo_d     = 1'b0;
`ifdef INTCTL_MULTI_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A low grant here belongs to someone downstream; don't raise BR into it.
                if (any_req && bus.bg_in_l) begin
                    state_d  = S_REQ;
                    br_d     = 1'b1;
                    dg_cnt_d = '0;
                end
            end
            S_REQ: begin
                if (bus.bg_in_l) begin
                    dg_cnt_d = '0;
                    if (!any_req) begin
                        br_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (dg_cnt_q != DGW'(DEGLITCH)) begin
                    dg_cnt_d = dg_cnt_q + 1'b1;
                end else begin
                    br_d     = 1'b0;
                    sack_d   = 1'b1;
                    dg_cnt_d = '0;
                    state_d  = S_SACK;
                end
            end
            S_SACK: begin
                if (bus_free) begin
                    sack_d = 1'b0;
                    if (pick_ok) begin
                        win_d     = pick;
                        bbsy_d    = 1'b1;
                        intr_d    = 1'b1;
                        d_d       = {8'h00, pick_vec & 8'hFC};
                        tmo_cnt_d = '0;
                        state_d   = S_INTR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_INTR: begin
                if (bus.syn_ssyn_in_h || tmo_cnt_q == TMW'(TIMEOUT)) begin
                    bbsy_d  = 1'b0;
                    intr_d  = 1'b0;
                    d_d     = '0;
                    state_d = S_IDLE;
                    if (bus.syn_ssyn_in_h) begin
                        for (int k = 0; k < NCHAN; k++) ack_d[k] = (win_q == IDXW'(k));
`ifdef INTCTL_MULTI_RR_EN
                        ptr_d = (win_q == IDXW'(NCHAN - 1)) ? '0 : win_q + 1'b1;
`endif
                    end else begin
                        tmo_d = 1'b1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || bus.init_in_h) begin
            state_q   <= S_IDLE;
            dg_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            win_q     <= '0;
            br_q      <= 1'b0;
            sack_q    <= 1'b0;
            bbsy_q    <= 1'b0;
            intr_q    <= 1'b0;
            d_q       <= '0;
            ack_q     <= '0;
            tmo_q     <= 1'b0;
`ifdef INTCTL_MULTI_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dg_cnt_q  <= dg_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            win_q     <= win_d;
            br_q      <= br_d;
            sack_q    <= sack_d;
            bbsy_q    <= bbsy_d;
            intr_q    <= intr_d;
            d_q       <= d_d;
            ack_q     <= ack_d;
            tmo_q     <= tmo_d;
`ifdef INTCTL_MULTI_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.br_out_h   = br_q;
    assign bus.sack_out_h = sack_q;
    assign bus.bbsy_out_h = bbsy_q;
    assign bus.intr_out_h = intr_q;
    assign bus.d_out_h    = d_q;
    assign intack_out_h   = ack_q;
    assign tmo_out_h      = tmo_q;
endmodule

// File: doc/intctl_multi.md
# intctl_multi

Parametrised single-level Unibus interrupt requester shared by NCHAN device channels. Runs BR/BG/SACK/BBSY/INTR arbitration for one bus-request level with a deglitched grant. Picks one requesting channel when it takes the bus, drives that channel's vector, and returns a per-channel acknowledge. Adds SSYN timeout recovery and request-withdrawal release, and sits between device register blocks and the Unibus pin drivers.

## Interface
- NCHAN, 4: number of device channels, 1..16
- DEGLITCH, 4: grant is accepted after DEGLITCH+1 consecutive low samples of bg_in_l
- TIMEOUT, 255: cycles to wait for SSYN after INTR before abandoning; 1..65535
- CLOCK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- intvecs  in  8*NCHAN  channel i vector at [8i+7:8i]; bit0=1 means no request, otherwise a vector (4-byte aligned)
- bbsy_in_h, bg_in_l, init_in_h, syn_msyn_in_h, syn_ssyn_in_h  in  1 each  Unibus inputs (bg active-low)
- bbsy_out_h, br_out_h, intr_out_h, sack_out_h  out  1 each  Unibus drives
- d_out_h  out  16  vector on data lines, 0 when idle
- intack_out_h  out  NCHAN  one-cycle pulse; channel's vector accepted by CPU
- tmo_out_h  out  1  one-cycle pulse; SSYN timeout

## Operation
- RESET or init_in_h, sampled on an edge: state IDLE; all outputs 0; counters 0; round-robin pointer 0. Either one overrides any state.
- IDLE: if any channel is requesting and bg_in_l=1, go to REQ with br_out_h=1 and deglitch count=0. If bg_in_l=0, hold in IDLE so a downstream grant is not stolen.
- REQ: br_out_h=1.
  - If bg_in_l=1: count=0. If no channel is requesting, br_out_h=0 and go to IDLE.
  - If bg_in_l=0 and count≠DEGLITCH: count+1.
  - Otherwise: br_out_h=0, sack_out_h=1, go to SACK.
  - A request withdrawn while bg_in_l=0 does not abort the grant.
- SACK: wait for bbsy_in_h=0, bg_in_l=1, syn_msyn_in_h=0 and syn_ssyn_in_h=0 on the same edge. Then sack_out_h=0 and arbitrate among currently requesting channels.
  - Winner found: latch winner index; bbsy_out_h=1, intr_out_h=1, d_out_h={8'b0, vec[7:2], 2'b00}; timeout count=0; go to INTR.
  - No winner: go to IDLE with no bus cycle.
- INTR:
  - syn_ssyn_in_h=1: bbsy_out_h, intr_out_h, d_out_h go to 0. intack_out_h[winner] pulses for one cycle. Round-robin pointer = winner+1 mod NCHAN. Go to IDLE.
  - Timeout count reaches TIMEOUT: same teardown, but tmo_out_h pulses, no intack, pointer unchanged, go to IDLE.
- Vector is latched at bus take. Later intvecs changes do not alter d_out_h.
- intack_out_h and tmo_out_h are never asserted in the same cycle. At most one intack bit is set at a time.

## Timing
- Request to br_out_h: 1 edge.
- bg_in_l low to sack_out_h: DEGLITCH+1 edges (default 5). Any high sample restarts the count.
- Bus-free condition to bbsy/intr/d: 1 edge, with sack dropping on the same edge.
- SSYN to teardown and intack: 1 edge.
- Timeout: tmo_out_h on edge TIMEOUT+1 after intr_out_h rises.
- Minimum gap between consecutive interrupts: one IDLE cycle.
- Counter widths are $clog2 of their maximum value plus 1.

## Configuration
- INTCTL_MULTI_RR_EN defined: round-robin arbitration. Search begins at the pointer and wraps modulo NCHAN; the first requesting channel wins.
- Undefined: fixed priority, lowest index wins. Pointer logic is omitted.

## Test plan
- Fixed priority, ch1=0o104 and ch3=0o060 requesting, bg low 5 cycles then bus free: d_out_h=0o104, intr=1; SSYN gives intack_out_h=4'b0010 for 1 cycle and d_out_h=0.
- Grant glitch: bg_in_l low 3 cycles, high 1, low 5: sack asserts only after the final 5th low sample; br stays 1 throughout.
- Withdrawal: ch0 requests and withdraws before bus free: sack drops, no bbsy/intr, no intack. Withdrawal in REQ with bg high: br drops next edge.
- Timeout (TIMEOUT=255): no SSYN: tmo_out_h pulse at edge 256, bus lines 0, no intack.
- RR_EN with ch0 and ch2 both continuously requesting: grants alternate 0,2,0,2; fixed build grants 0 every time.
- init_in_h pulsed while in INTR: next edge all outputs 0 and state IDLE; request resumes afterward.
